// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin packet-locking arbiter for the uart TX FIFO write port
// Optional stall watchdog enabled by defining UART_ARB_TIMEOUT_EN.
module uart_tx_arbiter #(
  parameter int NREQ    = 4,
  parameter int N       = 8,
  parameter int MAXLEN  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_full,
  output logic              w_uart,
  output logic [N-1:0]      w_data,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              timeout_evt
);

  localparam int IW = $clog2(NREQ);

  typedef enum logic {IDLE, XFER} state_t;

  state_t        state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] owner;
  logic [7:0]    byte_cnt;
  logic [IW-1:0] pick;
  logic          pick_ok;
  int            idx;
  logic          cap_hit;
  logic          release_last;
  logic          stall_hit;
  logic [IW-1:0] next_rr;

  // Search for the first valid requester starting at rr_ptr, wrapping around.
  always_comb begin
    pick    = '0;
    pick_ok = 1'b0;
    idx     = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!pick_ok && req_valid[idx]) begin
        pick    = IW'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  // Owner-side handshake and FIFO write, driven from the registered owner only.
  always_comb begin
    req_ready = '0;
    w_uart    = 1'b0;
    w_data    = '0;
    if (state == XFER) begin
      req_ready[owner] = !tx_full;
      w_uart           = req_valid[owner] & !tx_full;
    end
    if (w_uart) w_data = req_data[int'(owner)*N +: N];
  end

  assign cap_hit      = ({1'b0, byte_cnt} + 9'd1) == 9'(MAXLEN);
  assign release_last = w_uart & (req_last[owner] | cap_hit);
  assign next_rr      = (int'(owner) == NREQ - 1) ? '0 : owner + 1'b1;

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] stall_cnt;

  assign stall_hit = (state == XFER) && !req_valid[owner] &&
                     (({1'b0, stall_cnt} + 9'd1) == 9'(TIMEOUT));

  // Count owner cycles without a byte offered; FIFO-full stalls are not the owner's fault.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (state != XFER || w_uart) begin
      stall_cnt <= '0;
    end else if (!req_valid[owner]) begin
      stall_cnt <= stall_cnt + 8'd1;
    end
  end
`else
  assign stall_hit = 1'b0;
`endif

  // Grant/release FSM; grant, busy and timeout_evt are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      grant       <= '0;
      busy        <= 1'b0;
      rr_ptr      <= '0;
      owner       <= '0;
      byte_cnt    <= '0;
      timeout_evt <= 1'b0;
    end else begin
      timeout_evt <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_ok) begin
            state    <= XFER;
            grant    <= NREQ'(1) << pick;
            owner    <= pick;
            busy     <= 1'b1;
            byte_cnt <= '0;
          end
        end
        XFER: begin
          if (release_last || stall_hit) begin
            state       <= IDLE;
            grant       <= '0;
            busy        <= 1'b0;
            rr_ptr      <= next_rr;
            timeout_evt <= stall_hit & !release_last;
          end else if (w_uart) begin
            byte_cnt <= byte_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - directed vector bench for uart_tx_arbiter (MAXLEN=4, TIMEOUT=8)
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        tx_full;
  logic        w_uart;
  logic [7:0]  w_data;
  logic [3:0]  grant;
  logic        busy;
  logic        timeout_evt;

  int n_vec = 0;
  int n_err = 0;

  uart_tx_arbiter #(.NREQ(4), .N(8), .MAXLEN(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_full(tx_full),
    .w_uart(w_uart), .w_data(w_data), .grant(grant), .busy(busy),
    .timeout_evt(timeout_evt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        f;
    logic        ew;
    logic [7:0]  ed;
    logic [3:0]  eg;
    logic        eb;
    logic [3:0]  er;
    logic        eto;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic f, input logic ew,
                              input logic [7:0] ed, input logic [3:0] eg, input logic eb,
                              input logic [3:0] er, input logic eto);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.l = l; x.f = f;
    x.ew = ew; x.ed = ed; x.eg = eg; x.eb = eb; x.er = er; x.eto = eto;
    vq.push_back(x);
  endfunction

  // idle-state expectation shorthand
  function automatic void add_idle(input logic r, input logic [3:0] v, input logic [31:0] d,
                                   input logic [3:0] l, input logic eto);
    add(r, v, d, l, 1'b0, 1'b0, 8'h00, 4'b0000, 1'b0, 4'b0000, eto);
  endfunction

  task automatic chk(input int id, input string nm, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL vec %0d %s: got %h expected %h", id, nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic f);
    rst = r; req_valid = v; req_data = d; req_last = l; tx_full = f;
  endtask

  initial begin
    drive(1'b0, 4'b0, 32'b0, 4'b0, 1'b0);

    // reset held with random inputs: nothing may be granted or written
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 4'($urandom), $urandom, 4'($urandom), 1'($urandom));
      #1;
      n_vec++;
      chk(1000 + i, "rst_grant", 32'(grant), 32'h0);
      chk(1000 + i, "rst_w_uart", 32'(w_uart), 32'h0);
      chk(1000 + i, "rst_ready", 32'(req_ready), 32'h0);
      chk(1000 + i, "rst_busy", 32'(busy), 32'h0);
    end

    // reset mid-packet: async abort, no write while rst low
    @(posedge clk); #1;
    drive(1'b1, 4'b0001, 32'h77, 4'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_vec++;
    chk(2000, "mid_w_uart_before", 32'(w_uart), 32'h1);
    rst = 1'b0;
    #1;
    n_vec++;
    chk(2001, "mid_w_uart", 32'(w_uart), 32'h0);
    chk(2001, "mid_grant", 32'(grant), 32'h0);
    chk(2001, "mid_busy", 32'(busy), 32'h0);
    chk(2001, "mid_ready", 32'(req_ready), 32'h0);

    // single packet from req0
    add_idle(0, 4'b0000, 32'h0, 4'b0, 0);
    add_idle(1, 4'b0001, 32'h41, 4'b0000, 0);
    add(1, 4'b0001, 32'h41, 4'b0000, 0, 1, 8'h41, 4'b0001, 1, 4'b0001, 0);
    add(1, 4'b0001, 32'h42, 4'b0000, 0, 1, 8'h42, 4'b0001, 1, 4'b0001, 0);
    add(1, 4'b0001, 32'h43, 4'b0001, 0, 1, 8'h43, 4'b0001, 1, 4'b0001, 0);
    add_idle(1, 4'b0000, 32'h0, 4'b0, 0);

    // round robin, all four requesting 1-byte packets
    add_idle(0, 4'b0000, 32'h0, 4'b0, 0);
    for (int k = 0; k < 5; k++) begin
      add_idle(1, 4'b1111, 32'h13121110, 4'b1111, 0);
      add(1, 4'b1111, 32'h13121110, 4'b1111, 0, 1, 8'(8'h10 + (k % 4)),
          4'(1 << (k % 4)), 1, 4'(1 << (k % 4)), 0);
    end
    add_idle(1, 4'b0000, 32'h0, 4'b0, 0);

    // back-pressure on req2 (rr_ptr is 1 here)
    add_idle(1, 4'b0100, 32'h00A00000, 4'b0, 0);
    add(1, 4'b0100, 32'h00A00000, 4'b0000, 0, 1, 8'hA0, 4'b0100, 1, 4'b0100, 0);
    for (int k = 0; k < 4; k++)
      add(1, 4'b0100, 32'h00A10000, 4'b0000, 1, 0, 8'h00, 4'b0100, 1, 4'b0000, 0);
    add(1, 4'b0100, 32'h00A10000, 4'b0000, 0, 1, 8'hA1, 4'b0100, 1, 4'b0100, 0);
    add(1, 4'b0100, 32'h00A20000, 4'b0000, 0, 1, 8'hA2, 4'b0100, 1, 4'b0100, 0);
    add(1, 4'b0100, 32'h00A30000, 4'b0100, 0, 1, 8'hA3, 4'b0100, 1, 4'b0100, 0);
    add_idle(1, 4'b0000, 32'h0, 4'b0, 0);

    // MAXLEN cap: req1 6 bytes, req3 waiting with a 1-byte packet
    add_idle(0, 4'b0000, 32'h0, 4'b0, 0);
    add_idle(1, 4'b1010, 32'hC000B000, 4'b1000, 0);
    add(1, 4'b1010, 32'hC000B000, 4'b1000, 0, 1, 8'hB0, 4'b0010, 1, 4'b0010, 0);
    add(1, 4'b1010, 32'hC000B100, 4'b1000, 0, 1, 8'hB1, 4'b0010, 1, 4'b0010, 0);
    add(1, 4'b1010, 32'hC000B200, 4'b1000, 0, 1, 8'hB2, 4'b0010, 1, 4'b0010, 0);
    add(1, 4'b1010, 32'hC000B300, 4'b1000, 0, 1, 8'hB3, 4'b0010, 1, 4'b0010, 0);
    add_idle(1, 4'b1010, 32'hC000B400, 4'b1000, 0);
    add(1, 4'b1010, 32'hC000B400, 4'b1000, 0, 1, 8'hC0, 4'b1000, 1, 4'b1000, 0);
    add_idle(1, 4'b0010, 32'h0000B400, 4'b0000, 0);
    add(1, 4'b0010, 32'h0000B400, 4'b0000, 0, 1, 8'hB4, 4'b0010, 1, 4'b0010, 0);
    add(1, 4'b0010, 32'h0000B500, 4'b0010, 0, 1, 8'hB5, 4'b0010, 1, 4'b0010, 0);
    add_idle(1, 4'b0000, 32'h0, 4'b0, 0);

`ifdef UART_ARB_TIMEOUT_EN
    // req0 sends one byte then goes silent; req1 pending
    add_idle(0, 4'b0000, 32'h0, 4'b0, 0);
    add_idle(1, 4'b0001, 32'h00000055, 4'b0000, 0);
    add(1, 4'b0001, 32'h00000055, 4'b0000, 0, 1, 8'h55, 4'b0001, 1, 4'b0001, 0);
    for (int k = 0; k < 8; k++)
      add(1, 4'b0010, 32'h00006600, 4'b0010, 0, 0, 8'h00, 4'b0001, 1, 4'b0001, 0);
    add_idle(1, 4'b0010, 32'h00006600, 4'b0010, 1);
    add(1, 4'b0010, 32'h00006600, 4'b0010, 0, 1, 8'h66, 4'b0010, 1, 4'b0010, 0);
    add_idle(1, 4'b0000, 32'h0, 4'b0, 0);
`endif

    foreach (vq[i]) begin
      @(posedge clk); #1;
      drive(vq[i].r, vq[i].v, vq[i].d, vq[i].l, vq[i].f);
      #1;
      n_vec++;
      chk(i, "w_uart", 32'(w_uart), 32'(vq[i].ew));
      chk(i, "w_data", 32'(w_data), 32'(vq[i].ed));
      chk(i, "grant", 32'(grant), 32'(vq[i].eg));
      chk(i, "busy", 32'(busy), 32'(vq[i].eb));
      chk(i, "req_ready", 32'(req_ready), 32'(vq[i].er));
      chk(i, "timeout_evt", 32'(timeout_evt), 32'(vq[i].eto));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin, packet-locking arbiter that shares the single UART transmit FIFO write port (w_uart/w_data, back-pressured by tx_full) among NREQ byte-stream requesters.
- Sits between client blocks (command responders, debug/log sources) and the uart top.
- Once a requester is granted, its packet goes out as a contiguous byte sequence. The grant holds until that requester's last byte, or until the MAXLEN cap is reached.

Parameters:
- NREQ, 4, number of requesters (2..8).
- N, 8, data width per byte; matches the uart data width.
- MAXLEN, 16, maximum bytes per grant before forced release (1..255).
- TIMEOUT, 64, owner-stall cycles before forced release; used only with UART_ARB_TIMEOUT_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted at 0).
- req_valid  in  NREQ  requester i has a byte on its data slice.
- req_data  in  NREQ*N  byte of requester i in bits [i*N +: N].
- req_last  in  NREQ  byte of requester i ends its packet.
- req_ready  out  NREQ  byte of requester i accepted this cycle when valid&ready.
- tx_full  in  1  uart TX FIFO full.
- w_uart  out  1  write strobe to the uart TX FIFO.
- w_data  out  N  byte to the uart TX FIFO.
- grant  out  NREQ  one-hot current owner (registered).
- busy  out  1  a grant is active.
- timeout_evt  out  1  one-cycle pulse on forced release by the stall watchdog (tied 0 without the macro).

Behaviour:
- Reset (rst=0, async) forces:
  - state=IDLE, grant=0, busy=0, rr_ptr=0, byte_cnt=0, timeout_evt=0.
  - Combinational outputs are then w_uart=0, w_data=0, req_ready=0.
- FSM states: IDLE, XFER.
- IDLE:
  - If any req_valid, pick the first valid index starting at rr_ptr, wrapping modulo NREQ.
  - Register grant=onehot(g), busy=1, byte_cnt=0; go to XFER.
  - Arbitration latency is exactly 1 cycle: valid at cycle t, first write possible at t+1.
  - No valid requester: stay in IDLE.
- XFER with owner g (all combinational from registered grant):
  - req_ready[g] = !tx_full; req_ready of every other index is 0.
  - w_uart = req_valid[g] & !tx_full.
  - w_data = req_data[g] when w_uart, else 0.
  - Transfer = w_uart; it increments byte_cnt (8-bit, never wraps because release occurs at MAXLEN).
- Release happens on a transfer with req_last[g]=1, or when byte_cnt+1 == MAXLEN. On release:
  - Go to IDLE with grant=0, busy=0, rr_ptr=(g+1) mod NREQ.
  - A MAXLEN release does not drop the remaining bytes. The requester keeps them and re-arbitrates.
- Back-pressure: tx_full=1 holds w_uart=0 and req_ready[g]=0. The grant is kept, and req_valid/req_data must stay stable.
- Owner drops req_valid mid-packet: grant is kept and no write is issued (see the optional watchdog).
- Other requesters' valid changes during XFER: ignored.
- Back-to-back releases: IDLE always costs 1 bubble cycle between packets.
- A single requester streaming packets is re-granted after that 1-cycle gap.
- Reset mid-packet: immediate abort with no partial write. A byte is written only when w_uart=1 at a clock edge.
- Invariants: grant is one-hot or zero; at most one req_ready is high; w_uart implies !tx_full.

Optional Feature:
- Macro: UART_ARB_TIMEOUT_EN.
- When defined:
  - An 8-bit stall counter clears on every transfer and on grant.
  - It increments each XFER cycle where req_valid[g]=0. tx_full stalls are not counted.
  - Reaching TIMEOUT forces release exactly as a last-byte release would (rr_ptr advances) and pulses timeout_evt for 1 cycle.
- When undefined: no counter is built, timeout_evt is tied 0, and the owner may hold the grant indefinitely.

Test Plan:
- Reset then idle: rst=0 with random inputs -> grant=0, w_uart=0, req_ready=0, busy=0 throughout.
- Single packet: req0 sends 0x41,0x42,0x43 (last on 0x43), tx_full=0 -> grant=0001 one cycle after valid; w_data=0x41,0x42,0x43 on 3 consecutive cycles; busy drops the following cycle.
- Round-robin fairness: req0..req3 all valid, 1-byte packets of 0x10+i, repeated -> write order 0x10,0x11,0x12,0x13,0x10, each separated by 1 idle cycle.
- Back-pressure: req2 sends a 4-byte packet with tx_full=1 for cycles 2-5 -> no w_uart and req_ready[2]=0 during the stall; all 4 bytes then arrive in order with none lost or duplicated.
- MAXLEN cap: MAXLEN=4, req1 sends 6 bytes, req3 waiting -> 4 bytes from req1, then req3's packet, then req1's remaining 2 bytes.
- Timeout (macro on, TIMEOUT=8): req0 sends 1 byte without last, then drops valid -> release after 8 cycles with a timeout_evt pulse; pending req1 is granted next.
